// File: rtl/regbank_arb_pkg.sv
// Shared types for the register-bank port arbiter: widths, write-queue entry and bank grant kinds.
package regbank_arb_pkg;

    localparam int REG_W = 16;
    localparam int IDX_W = 4;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [REG_W-1:0] data;
    } wq_entry_t;

    typedef enum logic [1:0] {
        G_IDLE,
        G_READ,
        G_WRITE
    } grant_e;

endpackage

// File: rtl/regbank_write_queue.sv
// Write-back queue: two enqueues and one dequeue per cycle, plus per-operand lookups that
// report whether any queued entry targets a register and the data of the youngest such entry.
module regbank_write_queue
    import regbank_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push0,
    input  logic [IDX_W-1:0]             push0_idx,
    input  logic [REG_W-1:0]             push0_data,
    input  logic                         push1,
    input  logic [IDX_W-1:0]             push1_idx,
    input  logic [REG_W-1:0]             push1_data,
    input  logic                         pop,
    output logic [IDX_W-1:0]             head_idx,
    output logic [REG_W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]       count,
    input  logic                         look_a_en,
    input  logic [IDX_W-1:0]             look_a_idx,
    input  logic [IDX_W-1:0]             look_b_idx,
    output logic                         match_a,
    output logic                         match_b,
    output logic [REG_W-1:0]             match_data_a,
    output logic [REG_W-1:0]             match_data_b
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wq_entry_t        mem_q [DEPTH];
    wq_entry_t        slot;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define which slots are live.
    always_ff @(posedge clk) begin
        if (push0) mem_q[wr_ptr_q] <= '{idx: push0_idx, data: push0_data};
        if (push1) mem_q[wr_ptr_q + PTR_W'(push0)] <= '{idx: push1_idx, data: push1_data};
    end

    assign head_idx  = mem_q[rd_ptr_q].idx;
    assign head_data = mem_q[rd_ptr_q].data;
    assign count     = count_q;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        match_a      = 1'b0;
        match_b      = 1'b0;
        match_data_a = '0;
        match_data_b = '0;
        slot         = '0;
        // Walk oldest to youngest so the last hit is the youngest matching entry.
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count_q) begin
                slot = mem_q[rd_ptr_q + PTR_W'(k)];
                if (look_a_en && slot.idx == look_a_idx) begin
                    match_a      = 1'b1;
                    match_data_a = slot.data;
                end
                if (slot.idx == look_b_idx) begin
                    match_b      = 1'b1;
                    match_data_b = slot.data;
                end
            end
        end
    end

endmodule

// File: rtl/regbank_port_arbiter.sv
// Arbitrates the single-port register bank between operand reads and queued write-backs.
// Optional macro REGBANK_FORWARD_EN lets hazarding reads issue and take queued data instead of draining.
module regbank_port_arbiter
    import regbank_arb_pkg::*;
#(
    parameter int WQ_DEPTH       = 4,
    parameter int MAX_READ_BURST = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    output logic        rd_ready,
    input  logic [3:0]  rd_regA,
    input  logic [3:0]  rd_regB,
    input  logic        rd_imm_flag,
    input  logic [15:0] rd_imm,
    output logic        rd_valid,
    output logic [15:0] rd_dataA,
    output logic [15:0] rd_dataB,
    input  logic        wb0_valid,
    output logic        wb0_ready,
    input  logic [3:0]  wb0_reg,
    input  logic [15:0] wb0_data,
    input  logic        wb1_valid,
    output logic        wb1_ready,
    input  logic [3:0]  wb1_reg,
    input  logic [15:0] wb1_data,
    output logic [3:0]  bank_regA,
    output logic [3:0]  bank_regB,
    output logic [3:0]  bank_regC,
    output logic [15:0] bank_dado,
    output logic        bank_RW,
    output logic        bank_flagImediato,
    output logic [15:0] bank_imediato,
    input  logic [15:0] bank_saidaA,
    input  logic [15:0] bank_saidaB,
    output logic [2:0]  wq_count,
    output logic        busy
);

    localparam int CNT_W   = $clog2(WQ_DEPTH) + 1;
    localparam int BURST_W = $clog2(MAX_READ_BURST + 1);

    grant_e             grant;
    logic               read_ok;
    logic               q_empty, q_full;
    logic [CNT_W-1:0]   count, free;
    logic [IDX_W-1:0]   head_idx;
    logic [REG_W-1:0]   head_data;
    logic               match_a, match_b;
    logic [REG_W-1:0]   match_data_a, match_data_b;
    logic               push0, push1;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               rd_valid_q, rd_valid_d;

    regbank_write_queue #(.DEPTH(WQ_DEPTH)) u_wq (
        .clk          (clk),
        .rst          (rst),
        .push0        (push0),
        .push0_idx    (wb0_reg),
        .push0_data   (wb0_data),
        .push1        (push1),
        .push1_idx    (wb1_reg),
        .push1_data   (wb1_data),
        .pop          (grant == G_WRITE),
        .head_idx     (head_idx),
        .head_data    (head_data),
        .count        (count),
        .look_a_en    (!rd_imm_flag),
        .look_a_idx   (rd_regA),
        .look_b_idx   (rd_regB),
        .match_a      (match_a),
        .match_b      (match_b),
        .match_data_a (match_data_a),
        .match_data_b (match_data_b)
    );

    assign q_empty = (count == '0);
    assign q_full  = (count == CNT_W'(WQ_DEPTH));

`ifdef REGBANK_FORWARD_EN
    assign read_ok = 1'b1;
`else
    assign read_ok = !(match_a || match_b);
`endif

    // A pending hazard always implies a non-empty queue, so draining and background writes share one branch.
    always_comb begin
        grant = G_IDLE;
        if (rst)
            grant = G_IDLE;
        else if (q_full)
            grant = G_WRITE;
        else if (rd_req && !q_empty && burst_q == BURST_W'(MAX_READ_BURST))
            grant = G_WRITE;
        else if (rd_req && read_ok)
            grant = G_READ;
        else if (!q_empty)
            grant = G_WRITE;
    end

    // Free slots count the dequeue happening this cycle, so a full queue still takes one write.
    assign free      = CNT_W'(WQ_DEPTH) - count + CNT_W'(grant == G_WRITE);
    assign wb0_ready = !rst && (free >= CNT_W'(1));
    assign wb1_ready = !rst && (free >= (wb0_valid ? CNT_W'(2) : CNT_W'(1)));
    assign push0     = wb0_valid && wb0_ready;
    assign push1     = wb1_valid && wb1_ready;

    always_comb begin
        rd_ready          = (grant == G_READ);
        bank_RW           = (grant == G_WRITE);
        bank_regA         = '0;
        bank_regB         = '0;
        bank_flagImediato = 1'b0;
        bank_imediato     = '0;
        bank_regC         = '0;
        bank_dado         = '0;
        if (grant == G_READ) begin
            bank_regA         = rd_regA;
            bank_regB         = rd_regB;
            bank_flagImediato = rd_imm_flag;
            bank_imediato     = rd_imm;
        end
        if (grant == G_WRITE) begin
            bank_regC = head_idx;
            bank_dado = head_data;
        end
    end

    // Reads only count toward the burst limit while writes are waiting behind them.
    always_comb begin
        burst_d    = burst_q;
        rd_valid_d = (grant == G_READ);
        if (grant == G_WRITE)
            burst_d = '0;
        else if (grant == G_READ)
            burst_d = q_empty ? '0 : burst_q + BURST_W'(1);
    end

`ifdef REGBANK_FORWARD_EN
    logic             fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [REG_W-1:0] fwd_data_a_q, fwd_data_a_d, fwd_data_b_q, fwd_data_b_d;

    always_comb begin
        fwd_a_d      = (grant == G_READ) && match_a;
        fwd_b_d      = (grant == G_READ) && match_b;
        fwd_data_a_d = match_data_a;
        fwd_data_b_d = match_data_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q      <= 1'b0;
            fwd_b_q      <= 1'b0;
            fwd_data_a_q <= '0;
            fwd_data_b_q <= '0;
        end else begin
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            fwd_data_a_q <= fwd_data_a_d;
            fwd_data_b_q <= fwd_data_b_d;
        end
    end
`else
    logic unused_fwd_data;
    assign unused_fwd_data = ^{match_data_a, match_data_b};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            burst_q    <= burst_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        rd_dataA = '0;
        rd_dataB = '0;
        if (rd_valid_q) begin
            rd_dataA = bank_saidaA;
            rd_dataB = bank_saidaB;
`ifdef REGBANK_FORWARD_EN
            if (fwd_a_q) rd_dataA = fwd_data_a_q;
            if (fwd_b_q) rd_dataB = fwd_data_b_q;
`endif
        end
    end

    assign rd_valid = rd_valid_q;
    assign wq_count = 3'(count);
    assign busy     = !q_empty || rd_valid_q;

endmodule

// File: tb/tb_regbank_port_arbiter.sv
// Self-checking bench: bank model, queue-based reference of arbitration and architectural register state.
module tb_regbank_port_arbiter;

    localparam int DEPTH = 4;
    localparam int MAXB  = 3;

    logic        clk, rst;
    logic        rd_req, rd_ready, rd_imm_flag, rd_valid;
    logic [3:0]  rd_regA, rd_regB;
    logic [15:0] rd_imm, rd_dataA, rd_dataB;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [3:0]  wb0_reg, wb1_reg;
    logic [15:0] wb0_data, wb1_data;
    logic [3:0]  bank_regA, bank_regB, bank_regC;
    logic [15:0] bank_dado, bank_imediato, bank_saidaA, bank_saidaB;
    logic        bank_RW, bank_flagImediato, busy;
    logic [2:0]  wq_count;

    regbank_port_arbiter #(.WQ_DEPTH(DEPTH), .MAX_READ_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_regA(rd_regA), .rd_regB(rd_regB),
        .rd_imm_flag(rd_imm_flag), .rd_imm(rd_imm),
        .rd_valid(rd_valid), .rd_dataA(rd_dataA), .rd_dataB(rd_dataB),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_reg(wb0_reg), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_reg(wb1_reg), .wb1_data(wb1_data),
        .bank_regA(bank_regA), .bank_regB(bank_regB), .bank_regC(bank_regC), .bank_dado(bank_dado),
        .bank_RW(bank_RW), .bank_flagImediato(bank_flagImediato), .bank_imediato(bank_imediato),
        .bank_saidaA(bank_saidaA), .bank_saidaB(bank_saidaB),
        .wq_count(wq_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model: one op per clock, read outputs registered.
    logic [15:0] bank_regs [16];
    always @(posedge clk) begin
        if (bank_RW) bank_regs[bank_regC] <= bank_dado;
        else begin
            bank_saidaA <= bank_flagImediato ? bank_imediato : bank_regs[bank_regA];
            bank_saidaB <= bank_regs[bank_regB];
        end
    end

    typedef struct { logic [3:0] idx; logic [15:0] data; } ent_t;

    ent_t        mq[$];
    logic [15:0] arch [16];
    int          checks = 0;
    int          errors = 0;
    int          mburst = 0;
    bit          pend = 0;
    logic [15:0] pend_a, pend_b;
    int          exp_g;
    bit          exp_wr0, exp_wr1;
    bit          n_pend;
    logic [15:0] n_pa, n_pb;
    bit          e_rst, e_push0, e_push1;
    ent_t        e_ent0, e_ent1;
    int          obs_g;
    logic        obs_wb0r, obs_wb1r;
    bit          last_acc = 0;
    int          stall = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected grant and readies from the priority rules, applied to the reference queue.
    task automatic eval_cycle();
        int cnt, free;
        bit haz, fwd;
        obs_g    = rd_ready ? 1 : (bank_RW ? 2 : 0);
        obs_wb0r = wb0_ready;
        obs_wb1r = wb1_ready;
        e_rst    = rst;
`ifdef REGBANK_FORWARD_EN
        fwd = 1;
`else
        fwd = 0;
`endif
        if (rst) begin
            mq.delete();
            mburst = 0;
            pend   = 0;
            for (int r = 0; r < 16; r++) arch[r] = bank_regs[r];
            exp_g = 0; exp_wr0 = 0; exp_wr1 = 0;
        end else begin
            cnt = mq.size();
            haz = 0;
            foreach (mq[i])
                if (mq[i].idx == rd_regB || (!rd_imm_flag && mq[i].idx == rd_regA)) haz = 1;
            if (cnt == DEPTH)                                exp_g = 2;
            else if (rd_req && cnt > 0 && mburst == MAXB)    exp_g = 2;
            else if (rd_req && (!haz || fwd))                exp_g = 1;
            else if (cnt > 0)                                exp_g = 2;
            else                                             exp_g = 0;
            free    = DEPTH - cnt + ((exp_g == 2) ? 1 : 0);
            exp_wr0 = (free >= 1);
            exp_wr1 = (free >= (wb0_valid ? 2 : 1));
        end
        cnt = mq.size();
        check("rd_ready", 32'(rd_ready), 32'(exp_g == 1));
        check("bank_RW", 32'(bank_RW), 32'(exp_g == 2));
        check("wb0_ready", 32'(wb0_ready), 32'(exp_wr0));
        check("wb1_ready", 32'(wb1_ready), 32'(exp_wr1));
        check("wq_count", 32'(wq_count), 32'(cnt));
        check("busy", 32'(busy), 32'(cnt > 0 || pend));
        check("rd_valid", 32'(rd_valid), 32'(pend));
        if (exp_g == 2) begin
            check("bank_regC", 32'(bank_regC), 32'(mq[0].idx));
            check("bank_dado", 32'(bank_dado), 32'(mq[0].data));
        end
        if (pend) begin
            check("rd_dataA", 32'(rd_dataA), 32'(pend_a));
            check("rd_dataB", 32'(rd_dataB), 32'(pend_b));
        end
        n_pend  = (exp_g == 1);
        n_pa    = rd_imm_flag ? rd_imm : arch[rd_regA];
        n_pb    = arch[rd_regB];
        e_push0 = wb0_valid && exp_wr0;
        e_push1 = wb1_valid && exp_wr1;
        e_ent0  = '{wb0_reg, wb0_data};
        e_ent1  = '{wb1_reg, wb1_data};
        last_acc = rd_req && rd_ready;
        if (!rst && rd_req && !rd_ready) stall++; else stall = 0;
        if (stall > 20) begin
            check("read_stall", 32'(stall), 32'(0));
            stall = 0;
        end
    endtask

    task automatic update_cycle();
        if (e_rst) return;
        if (exp_g == 2) mburst = 0;
        else if (exp_g == 1) mburst = (mq.size() > 0) ? mburst + 1 : 0;
        if (exp_g == 2) void'(mq.pop_front());
        if (e_push0) begin mq.push_back(e_ent0); arch[e_ent0.idx] = e_ent0.data; end
        if (e_push1) begin mq.push_back(e_ent1); arch[e_ent1.idx] = e_ent1.data; end
        pend   = n_pend;
        pend_a = n_pa;
        pend_b = n_pb;
    endtask

    task automatic tick();
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        update_cycle();
        #1;
    endtask

    task automatic idle_inputs();
        rd_req = 0; rd_imm_flag = 0; rd_regA = 0; rd_regB = 0; rd_imm = 0;
        wb0_valid = 0; wb1_valid = 0; wb0_reg = 0; wb1_reg = 0; wb0_data = 0; wb1_data = 0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 12 && wq_count != 0; i++) tick();
        check("drain", 32'(wq_count), 32'(0));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit got;
        for (int r = 0; r < 16; r++) bank_regs[r] = 16'h0100 * 16'(r);
        bank_regs[3] = 16'h0011;
        bank_regs[5] = 16'h0022;
        for (int r = 0; r < 16; r++) arch[r] = bank_regs[r];
        bank_saidaA = 0; bank_saidaB = 0;
        idle_inputs();
        rst = 1;
        tick();
        rd_req = 1; wb0_valid = 1;
        tick();
        check("reset_rd_ready_gated", 32'(obs_g), 32'(0));
        idle_inputs();
        rst = 0;
        tick();

        // Test 1: plain read on empty queue
        rd_req = 1; rd_regA = 3; rd_regB = 5;
        tick();
        check("t1_grant", 32'(obs_g), 32'(1));
        rd_req = 0;
        check("t1_valid", 32'(rd_valid), 32'(1));
        check("t1_dataA", 32'(rd_dataA), 32'h0011);
        check("t1_dataB", 32'(rd_dataB), 32'h0022);
        tick();

        // Test 2: two same-cycle writes to R2 then a read of R2
        wb0_valid = 1; wb0_reg = 2; wb0_data = 16'hAAAA;
        wb1_valid = 1; wb1_reg = 2; wb1_data = 16'hBBBB;
        tick();
        wb0_valid = 0; wb1_valid = 0;
        rd_req = 1; rd_regA = 0; rd_regB = 2;
        got = 0; n = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            n++;
            if (obs_g == 1) got = 1;
        end
`ifdef REGBANK_FORWARD_EN
        check("t2_grant_latency", 32'(n), 32'(1));
`else
        check("t2_grant_latency", 32'(n), 32'(3));
`endif
        rd_req = 0;
        check("t2_dataB", 32'(rd_dataB), 32'hBBBB);
        drain();
        check("t2_R2_final", 32'(bank_regs[2]), 32'hBBBB);

        // Test 3: fill the queue, then a full queue writes even with rd_req
        wb0_valid = 1; wb0_reg = 10; wb0_data = 16'h1010;
        wb1_valid = 1; wb1_reg = 11; wb1_data = 16'h1111;
        for (int i = 0; i < 8 && wq_count != 3'd4; i++) tick();
        check("t3_full", 32'(wq_count), 32'(4));
        rd_req = 1; rd_regA = 1; rd_regB = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_full_writes", 32'(obs_g), 32'(2));
            check("t3_wb0_ready", 32'(obs_wb0r), 32'(1));
            check("t3_wb1_ready", 32'(obs_wb1r), 32'(0));
        end
        drain();

        // Test 4: continuous reads with one queued write -> R,R,R,W
        rd_req = 1; rd_regA = 1; rd_regB = 1;
        for (int r = 0; r < 2; r++) begin
            wb0_valid = 1; wb0_reg = 9; wb0_data = 16'(16'h9000 + r);
            tick();
            wb0_valid = 0;
            for (int k = 0; k < 4; k++) begin
                tick();
                check("t4_burst_pattern", 32'(obs_g), 32'((k < 3) ? 1 : 2));
            end
        end
        drain();

        // Test 5: immediate operand A does not hazard against queued R7
        wb0_valid = 1; wb0_reg = 7; wb0_data = 16'h7777;
        tick();
        wb0_valid = 0;
        rd_req = 1; rd_imm_flag = 1; rd_imm = 16'h1234; rd_regA = 7; rd_regB = 1;
        tick();
        check("t5_grant", 32'(obs_g), 32'(1));
        rd_req = 0; rd_imm_flag = 0;
        check("t5_dataA", 32'(rd_dataA), 32'h1234);
        drain();

        // Test 6: reset with queued writes and a read response pending
        wb0_valid = 1; wb0_reg = 12; wb0_data = 16'hCCCC;
        wb1_valid = 1; wb1_reg = 13; wb1_data = 16'hDDDD;
        tick();
        wb1_valid = 0;
        wb0_reg = 14; wb0_data = 16'hEEEE;
        rd_req = 1; rd_regA = 1; rd_regB = 1;
        tick();
        idle_inputs();
        check("t6_pre_count", 32'(wq_count), 32'(3));
        rst = 1;
        #1;
        check("t6_rst_count", 32'(wq_count), 32'(0));
        check("t6_rst_valid", 32'(rd_valid), 32'(0));
        check("t6_rst_rw", 32'(bank_RW), 32'(0));
        check("t6_rst_busy", 32'(busy), 32'(0));
        tick();
        rst = 0;
        tick();

        // Randomized traffic against the reference model
        for (int c = 0; c < 500; c++) begin
            if (!rd_req || last_acc) begin
                rd_req      = ($urandom_range(0, 99) < 60);
                rd_regA     = 4'($urandom_range(0, 5));
                rd_regB     = 4'($urandom_range(0, 5));
                rd_imm_flag = ($urandom_range(0, 3) == 0);
                rd_imm      = 16'($urandom);
            end
            wb0_valid = ($urandom_range(0, 99) < 40);
            wb0_reg   = 4'($urandom_range(0, 5));
            wb0_data  = 16'($urandom);
            wb1_valid = ($urandom_range(0, 99) < 30);
            wb1_reg   = 4'($urandom_range(0, 5));
            wb1_data  = 16'($urandom);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
